// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_controller_pkg;

  localparam int unsigned OFFSETL     = 2;
  localparam int unsigned BLOCK_WORDS = 1 << OFFSETL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FETCH,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cache_controller_line_store.sv
// Line storage: valid bits (async clear), tags and 4-word data per line.
// One index serves the read port, full-line fill and single-word update.
module cache_controller_line_store
  import cache_controller_pkg::*;
#(
  parameter int unsigned WORD   = 32,
  parameter int unsigned INDEXL = 10,
  parameter int unsigned TAGL   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INDEXL-1:0]                   index,
  output logic                                rd_valid,
  output logic [TAGL-1:0]                     rd_tag,
  output logic [BLOCK_WORDS-1:0][WORD-1:0]    rd_line,
  input  logic                                fill_en,
  input  logic [TAGL-1:0]                     fill_tag,
  input  logic [BLOCK_WORDS-1:0][WORD-1:0]    fill_data,
  input  logic                                upd_en,
  input  logic [OFFSETL-1:0]                  upd_offset,
  input  logic [WORD-1:0]                     upd_data
);

  localparam int unsigned LINES = 2 ** INDEXL;

  logic [LINES-1:0]                 valid_q;
  logic [TAGL-1:0]                  tag_q  [LINES];
  logic [BLOCK_WORDS-1:0][WORD-1:0] data_q [LINES];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  // Only the valid bits are reset; stale tag/data behind a cleared valid is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (upd_en) begin
      data_q[index][upd_offset] <= upd_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU request/ready
// interface and a word/4-word-block data memory, with hit and read-access counters.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned WORD     = 32,
  parameter int unsigned ADDRESSL = 15,
  parameter int unsigned INDEXL   = 10,
  parameter int unsigned MEM_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDRESSL-1:0] cpuAddress,
  input  logic                cpuRead,
  input  logic                cpuWrite,
  input  logic [WORD-1:0]     cpuWriteData,
  output logic [WORD-1:0]     cpuReadData,
  output logic                ready,
  output logic                hit,
  output logic [ADDRESSL-1:0] memAddress,
  output logic [ADDRESSL-1:0] memAddress0,
  output logic [ADDRESSL-1:0] memAddress1,
  output logic [ADDRESSL-1:0] memAddress2,
  output logic [ADDRESSL-1:0] memAddress3,
  output logic                memRead,
  output logic                memWrite,
  output logic [WORD-1:0]     memWriteData,
  input  logic [WORD-1:0]     memBlock0,
  input  logic [WORD-1:0]     memBlock1,
  input  logic [WORD-1:0]     memBlock2,
  input  logic [WORD-1:0]     memBlock3,
  output logic [31:0]         hitCount,
  output logic [31:0]         accessCount
);

  localparam int unsigned TAGL = ADDRESSL - INDEXL - OFFSETL;
  localparam int unsigned CNTW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_e                              state_q, state_d;
  logic [ADDRESSL-1:0]                 addr_q, addr_d;
  logic [WORD-1:0]                     wdata_q, wdata_d;
  logic                                is_write_q, is_write_d;
  logic                                line_hit_q, line_hit_d;
  logic [CNTW-1:0]                     cnt_q, cnt_d;
  logic                                ready_q, ready_d;
  logic                                hit_q, hit_d;
  logic                                mem_read_q, mem_read_d;
  logic                                mem_write_q, mem_write_d;
  logic [ADDRESSL-1:0]                 mem_addr_q, mem_addr_d;
  logic [BLOCK_WORDS-1:0][ADDRESSL-1:0] blk_addr_q, blk_addr_d;
  logic [WORD-1:0]                     mem_wdata_q, mem_wdata_d;
  logic [WORD-1:0]                     rdata_q, rdata_d;
  logic [31:0]                         hit_count_q, hit_count_d;
  logic [31:0]                         access_count_q, access_count_d;

  logic [INDEXL-1:0]                   look_index_c;
  logic [TAGL-1:0]                     look_tag_c;
  logic [OFFSETL-1:0]                  offset_c;
  logic                                rd_valid_c;
  logic [TAGL-1:0]                     rd_tag_c;
  logic [BLOCK_WORDS-1:0][WORD-1:0]    rd_line_c;
  logic [BLOCK_WORDS-1:0][WORD-1:0]    mem_block_c;
  logic                                line_hit_c;
  logic                                fill_en_c;
  logic                                upd_en_c;

  // In IDLE the store is probed with the incoming address so hit can pulse in LOOKUP.
  assign look_index_c = (state_q == ST_IDLE) ? cpuAddress[INDEXL+OFFSETL-1:OFFSETL]
                                             : addr_q[INDEXL+OFFSETL-1:OFFSETL];
  assign look_tag_c   = (state_q == ST_IDLE) ? cpuAddress[ADDRESSL-1:INDEXL+OFFSETL]
                                             : addr_q[ADDRESSL-1:INDEXL+OFFSETL];
  assign offset_c     = addr_q[OFFSETL-1:0];
  assign line_hit_c   = rd_valid_c && (rd_tag_c == look_tag_c);
  assign mem_block_c  = {memBlock3, memBlock2, memBlock1, memBlock0};

  cache_controller_line_store #(
    .WORD   (WORD),
    .INDEXL (INDEXL),
    .TAGL   (TAGL)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (look_index_c),
    .rd_valid   (rd_valid_c),
    .rd_tag     (rd_tag_c),
    .rd_line    (rd_line_c),
    .fill_en    (fill_en_c),
    .fill_tag   (look_tag_c),
    .fill_data  (mem_block_c),
    .upd_en     (upd_en_c),
    .upd_offset (offset_c),
    .upd_data   (wdata_q)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    is_write_d     = is_write_q;
    line_hit_d     = line_hit_q;
    cnt_d          = cnt_q;
    ready_d        = 1'b0;
    hit_d          = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    blk_addr_d     = blk_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rdata_d        = rdata_q;
    hit_count_d    = hit_count_q;
    access_count_d = access_count_q;
    fill_en_c      = 1'b0;
    upd_en_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpuRead || cpuWrite) begin
          addr_d     = cpuAddress;
          wdata_d    = cpuWriteData;
          is_write_d = cpuWrite;
          line_hit_d = line_hit_c;
          hit_d      = !cpuWrite && line_hit_c;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (is_write_q) begin
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = ST_WRITE;
        end else begin
          access_count_d = access_count_q + 32'd1;
          if (line_hit_q) begin
            rdata_d     = rd_line_c[offset_c];
            hit_count_d = hit_count_q + 32'd1;
            ready_d     = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_d      = '0;
            mem_read_d = 1'b1;
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
              blk_addr_d[i] = {addr_q[ADDRESSL-1:OFFSETL], OFFSETL'(i)};
            end
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (cnt_q == CNTW'(MEM_WAIT - 1)) begin
          fill_en_c = 1'b1;
          rdata_d   = mem_block_c[offset_c];
          ready_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          mem_read_d = 1'b1;
          cnt_d      = cnt_q + CNTW'(1);
        end
      end
      ST_WRITE: begin
        upd_en_c = line_hit_q;
        ready_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      is_write_q     <= 1'b0;
      line_hit_q     <= 1'b0;
      cnt_q          <= '0;
      ready_q        <= 1'b0;
      hit_q          <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      blk_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rdata_q        <= '0;
      hit_count_q    <= '0;
      access_count_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      is_write_q     <= is_write_d;
      line_hit_q     <= line_hit_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      hit_q          <= hit_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      blk_addr_q     <= blk_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rdata_q        <= rdata_d;
      hit_count_q    <= hit_count_d;
      access_count_q <= access_count_d;
    end
  end

  assign cpuReadData  = rdata_q;
  assign ready        = ready_q;
  assign hit          = hit_q;
  assign memAddress   = mem_addr_q;
  assign memAddress0  = blk_addr_q[0];
  assign memAddress1  = blk_addr_q[1];
  assign memAddress2  = blk_addr_q[2];
  assign memAddress3  = blk_addr_q[3];
  assign memRead      = mem_read_q;
  assign memWrite     = mem_write_q;
  assign memWriteData = mem_wdata_q;
  assign hitCount     = hit_count_q;
  assign accessCount  = access_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a data-memory model, a scoreboard queue of
// expected completions, and immediate-assertion checks of data, latency and counters.
module tb_cache_controller;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          hits;
    int          fetch;
    int          wrs;
    logic        is_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] cpuAddress;
  logic        cpuRead;
  logic        cpuWrite;
  logic [31:0] cpuWriteData;
  logic [31:0] cpuReadData;
  logic        ready;
  logic        hit;
  logic [14:0] memAddress;
  logic [14:0] memAddress0, memAddress1, memAddress2, memAddress3;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memWriteData;
  wire  [31:0] memBlock0, memBlock1, memBlock2, memBlock3;
  logic [31:0] hitCount;
  logic [31:0] accessCount;

  logic [31:0] mem [0:32767];
  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          exp_acc    = 0;
  int          exp_hits   = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpuAddress   (cpuAddress),
    .cpuRead      (cpuRead),
    .cpuWrite     (cpuWrite),
    .cpuWriteData (cpuWriteData),
    .cpuReadData  (cpuReadData),
    .ready        (ready),
    .hit          (hit),
    .memAddress   (memAddress),
    .memAddress0  (memAddress0),
    .memAddress1  (memAddress1),
    .memAddress2  (memAddress2),
    .memAddress3  (memAddress3),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memWriteData (memWriteData),
    .memBlock0    (memBlock0),
    .memBlock1    (memBlock1),
    .memBlock2    (memBlock2),
    .memBlock3    (memBlock3),
    .hitCount     (hitCount),
    .accessCount  (accessCount)
  );

  // Data memory: block ports float unless memRead is asserted.
  assign memBlock0 = memRead ? mem[memAddress0] : 'z;
  assign memBlock1 = memRead ? mem[memAddress1] : 'z;
  assign memBlock2 = memRead ? mem[memAddress2] : 'z;
  assign memBlock3 = memRead ? mem[memAddress3] : 'z;

  always @(posedge clk) begin
    if (memWrite) mem[memAddress] <= memWriteData;
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h5000_0000 | 32'(i);
    mem[15'h0010] = 32'hAAAA_AAAA;
    mem[15'h0011] = 32'hBBBB_BBBB;
    mem[15'h0012] = 32'hCCCC_CCCC;
    mem[15'h0013] = 32'hDDDD_DDDD;
    for (int i = 0; i < 4; i++) mem[15'h1010 + 15'(i)] = 32'hE000_0000 + 32'(i);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [14:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input int exp_lat,
                        input int exp_hit, input int exp_fetch);
    exp_t        e;
    int          cyc, lat, hseen, fseen, wseen;
    logic [31:0] got;
    logic [14:0] base;
    e = '{data: exp_data, lat: exp_lat, hits: exp_hit, fetch: exp_fetch,
          wrs: wr ? 1 : 0, is_rd: rd && !wr};
    sb.push_back(e);
    if (rd && !wr) begin
      exp_acc++;
      if (exp_hit != 0) exp_hits++;
    end
    base = addr & 15'h7FFC;
    @(negedge clk);
    cpuAddress = addr; cpuRead = rd; cpuWrite = wr; cpuWriteData = wd;
    cyc = 0; lat = -1; hseen = 0; fseen = 0; wseen = 0; got = '0;
    while (lat < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (hit) hseen++;
      if (memRead) begin
        if (fseen == 0) begin
          chk({name, "_addr0"}, 32'(memAddress0), 32'(base));
          chk({name, "_addr3"}, 32'(memAddress3), 32'(base + 15'd3));
        end
        fseen++;
      end
      if (memWrite) begin
        wseen++;
        chk({name, "_waddr"}, 32'(memAddress), 32'(addr));
        chk({name, "_wdata"}, memWriteData, wd);
      end
      if (ready) begin
        lat = cyc;
        got = cpuReadData;
      end
    end
    cpuRead = 1'b0; cpuWrite = 1'b0;
    e = sb.pop_front();
    chk({name, "_latency"}, 32'(lat), 32'(e.lat));
    chk({name, "_hits"}, 32'(hseen), 32'(e.hits));
    chk({name, "_fetch"}, 32'(fseen), 32'(e.fetch));
    chk({name, "_memwrite"}, 32'(wseen), 32'(e.wrs));
    if (e.is_rd) chk({name, "_data"}, got, e.data);
    @(posedge clk); #1;
    chk({name, "_ready_pulse"}, 32'(ready), 32'd0);
    chk({name, "_accessCount"}, accessCount, 32'(exp_acc));
    chk({name, "_hitCount"}, hitCount, 32'(exp_hits));
  endtask

  initial begin
    rst_n = 1'b1;
    cpuAddress = '0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuWriteData = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_memRead", 32'(memRead), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    chk("rst_rdata", cpuReadData, 32'd0);
    chk("rst_counts", hitCount | accessCount, 32'd0);
    chk("rst_addr", 32'(memAddress | memAddress1 | memAddress3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // cold miss, then hit in the same line
    do_req("cold_rd10", 1, 0, 15'h0010, '0, 32'hAAAA_AAAA, 6, 0, 4);
    do_req("hit_rd12",  1, 0, 15'h0012, '0, 32'hCCCC_CCCC, 2, 1, 0);

    // write hit updates memory and cache
    do_req("wr11", 0, 1, 15'h0011, 32'hDEAD_BEEF, '0, 3, 0, 0);
    chk("mem11", mem[15'h0011], 32'hDEAD_BEEF);
    do_req("hit_rd11", 1, 0, 15'h0011, '0, 32'hDEAD_BEEF, 2, 1, 0);

    // write miss does not allocate
    do_req("wr2000", 0, 1, 15'h2000, 32'h1234_5678, '0, 3, 0, 0);
    do_req("miss_rd2000", 1, 0, 15'h2000, '0, 32'h1234_5678, 6, 0, 4);

    // conflict on index 4: tag 0 vs tag 1
    do_req("conf_rd10a", 1, 0, 15'h0010, '0, 32'hAAAA_AAAA, 2, 1, 0);
    do_req("conf_rd1010", 1, 0, 15'h1010, '0, 32'hE000_0000, 6, 0, 4);
    do_req("conf_rd10b", 1, 0, 15'h0010, '0, 32'hAAAA_AAAA, 6, 0, 4);
    do_req("conf_rd1013", 1, 0, 15'h1013, '0, 32'hE000_0003, 6, 0, 4);

    // asynchronous reset during the second FETCH cycle
    @(negedge clk);
    cpuAddress = 15'h0010; cpuRead = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midfetch_memRead_before", 32'(memRead), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midfetch_memRead_after", 32'(memRead), 32'd0);
    chk("midfetch_accessCount", accessCount, 32'd0);
    chk("midfetch_addr0", 32'(memAddress0), 32'd0);
    cpuRead = 1'b0;
    exp_acc = 0; exp_hits = 0;
    @(negedge clk) rst_n = 1'b1;
    do_req("post_rst_rd10", 1, 0, 15'h0010, '0, 32'hAAAA_AAAA, 6, 0, 4);

    // read and write together behave as a write
    do_req("rw13", 1, 1, 15'h0013, 32'h0BAD_F00D, '0, 3, 0, 0);
    do_req("hit_rd13", 1, 0, 15'h0013, '0, 32'h0BAD_F00D, 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
